// File: rtl/ga_gen_ctrl.sv
// Generation sequencer for a GA core: launches fitness per individual, then selection and evolution per generation.
// Optional handshake watchdog is compiled in with `define GA_GEN_CTRL_TIMEOUT_EN.
module ga_gen_ctrl #(
  parameter int P_MAX   = 1024,
  parameter int G_MAX   = 1024,
  parameter int TIMEOUT = 65535,
  localparam int P_MAX_W     = $clog2(P_MAX + 1),
  localparam int P_IDX_MAX_W = $clog2(P_MAX),
  localparam int G_MAX_W     = $clog2(G_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [P_MAX_W-1:0]     i_cnfg_p,
  input  logic [G_MAX_W-1:0]     i_cnfg_g,
  input  logic                   i_valid_pls,
  input  logic                   i_fit_done,
  input  logic                   i_sel_done,
  input  logic                   i_evo_done,
  output logic                   o_fit_start,
  output logic [P_IDX_MAX_W-1:0] o_fit_idx,
  output logic                   o_sel_start,
  output logic                   o_evo_start,
  output logic [G_MAX_W-1:0]     o_gen_cntr,
  output logic                   o_valid_lvl,
  output logic                   ga_ready,
  output logic                   o_err
);

  typedef enum logic [2:0] {IDLE, FIT_LAUNCH, FIT_WAIT, SEL_WAIT, EVO_WAIT, DONE} state_t;

  state_t                   state_q, state_d;
  logic [P_MAX_W-1:0]       cfg_p;
  logic [G_MAX_W-1:0]       cfg_g;
  logic [P_IDX_MAX_W-1:0]   idx_q;
  logic [G_MAX_W-1:0]       gen_q;
  logic                     fit_start_q, sel_start_q, evo_start_q, valid_q;
  logic                     ready_st, accept, fit_last, gen_last, timeout_hit;

  function automatic logic [P_MAX_W-1:0] clamp_p(input logic [P_MAX_W-1:0] v);
    if (v == '0) return P_MAX_W'(1);
    if (v > P_MAX_W'(P_MAX)) return P_MAX_W'(P_MAX);
    return v;
  endfunction

  function automatic logic [G_MAX_W-1:0] clamp_g(input logic [G_MAX_W-1:0] v);
    if (v == '0) return G_MAX_W'(1);
    if (v > G_MAX_W'(G_MAX)) return G_MAX_W'(G_MAX);
    return v;
  endfunction

  assign ready_st = (state_q == IDLE) || (state_q == DONE);
  assign accept   = ready_st && i_valid_pls;
  assign fit_last = (P_MAX_W'(idx_q) == cfg_p - P_MAX_W'(1));
  assign gen_last = (gen_q == cfg_g - G_MAX_W'(1));

`ifdef GA_GEN_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q;
  logic            err_q, in_wait, done_hit;

  assign in_wait  = (state_q == FIT_WAIT) || (state_q == SEL_WAIT) || (state_q == EVO_WAIT);
  assign done_hit = ((state_q == FIT_WAIT) && i_fit_done) ||
                    ((state_q == SEL_WAIT) && i_sel_done) ||
                    ((state_q == EVO_WAIT) && i_evo_done);
  assign timeout_hit = in_wait && !done_hit && (wd_q == WD_W'(TIMEOUT - 1));

  // Watchdog restarts whenever a wait state is entered or left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q <= (in_wait && (state_d == state_q)) ? wd_q + 1'b1 : '0;
      if (accept)           err_q <= 1'b0;
      else if (timeout_hit) err_q <= 1'b1;
    end
  end
  assign o_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign timeout_hit    = 1'b0;
  assign o_err          = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (i_valid_pls) state_d = FIT_LAUNCH;
      FIT_LAUNCH: state_d = FIT_WAIT;
      FIT_WAIT: begin
        if (i_fit_done) begin
          if (!fit_last)     state_d = FIT_LAUNCH;
          else if (gen_last) state_d = DONE;
          else               state_d = SEL_WAIT;
        end
      end
      SEL_WAIT: if (i_sel_done) state_d = EVO_WAIT;
      EVO_WAIT: if (i_evo_done) state_d = FIT_LAUNCH;
      default:  state_d = IDLE;
    endcase
    if (timeout_hit) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cfg_p       <= P_MAX_W'(1);
      cfg_g       <= G_MAX_W'(1);
      idx_q       <= '0;
      gen_q       <= '0;
      fit_start_q <= 1'b0;
      sel_start_q <= 1'b0;
      evo_start_q <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      fit_start_q <= (state_d == FIT_LAUNCH);
      sel_start_q <= (state_q == FIT_WAIT) && (state_d == SEL_WAIT);
      evo_start_q <= (state_q == SEL_WAIT) && (state_d == EVO_WAIT);
      if (accept) begin
        cfg_p   <= clamp_p(i_cnfg_p);
        cfg_g   <= clamp_g(i_cnfg_g);
        idx_q   <= '0;
        gen_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        if ((state_q == FIT_WAIT) && i_fit_done && !timeout_hit)
          idx_q <= fit_last ? '0 : idx_q + 1'b1;
        if ((state_q == EVO_WAIT) && i_evo_done && !timeout_hit)
          gen_q <= gen_q + 1'b1;
        if ((state_q == FIT_WAIT) && (state_d == DONE))
          valid_q <= 1'b1;
        else if (timeout_hit)
          valid_q <= 1'b0;
      end
    end
  end

  assign o_fit_start = fit_start_q;
  assign o_fit_idx   = idx_q;
  assign o_sel_start = sel_start_q;
  assign o_evo_start = evo_start_q;
  assign o_gen_cntr  = gen_q;
  assign o_valid_lvl = valid_q;
  assign ga_ready    = !rst && ready_st;

endmodule

// File: tb/tb_ga_gen_ctrl.sv
// Randomized bench for ga_gen_ctrl: strobe-sequence reference model plus directed scenarios.
module tb_ga_gen_ctrl;
  localparam int P_MAX = 1024;
  localparam int G_MAX = 1024;
`ifdef GA_GEN_CTRL_TIMEOUT_EN
  localparam int TMO = 10;
`else
  localparam int TMO = 65535;
`endif
  localparam int PW = $clog2(P_MAX + 1);
  localparam int IW = $clog2(P_MAX);
  localparam int GW = $clog2(G_MAX + 1);
  localparam int C_SEL = -1, C_EVO = -2, C_NONE = -3;

  logic clk, rst;
  logic [PW-1:0] i_cnfg_p;
  logic [GW-1:0] i_cnfg_g;
  logic i_valid_pls, i_fit_done, i_sel_done, i_evo_done;
  logic o_fit_start, o_sel_start, o_evo_start, o_valid_lvl, ga_ready, o_err;
  logic [IW-1:0] o_fit_idx;
  logic [GW-1:0] o_gen_cntr;

  ga_gen_ctrl #(.P_MAX(P_MAX), .G_MAX(G_MAX), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .i_cnfg_p(i_cnfg_p), .i_cnfg_g(i_cnfg_g),
    .i_valid_pls(i_valid_pls), .i_fit_done(i_fit_done), .i_sel_done(i_sel_done),
    .i_evo_done(i_evo_done), .o_fit_start(o_fit_start), .o_fit_idx(o_fit_idx),
    .o_sel_start(o_sel_start), .o_evo_start(o_evo_start), .o_gen_cntr(o_gen_cntr),
    .o_valid_lvl(o_valid_lvl), .ga_ready(ga_ready), .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v < 1) ? 1 : ((v > hi) ? hi : v);
  endfunction

  // Reference model: the whole strobe sequence of a sample is queued on accept;
  // each strobe appears the cycle after its trigger (accept or the matching done).
  bit m_started, m_finished;
  int m_q[$];
  int m_exp, m_wait, m_idx, m_gen;

  task automatic model_reset();
    m_started = 0; m_finished = 0; m_q.delete();
    m_exp = C_NONE; m_wait = 0; m_idx = 0; m_gen = 0;
  endtask

  task automatic model_next();
    m_exp  = m_q.pop_front();
    m_wait = (m_exp >= 0) ? 1 : ((m_exp == C_SEL) ? 2 : 3);
    m_idx  = (m_exp >= 0) ? m_exp : 0;
  endtask

  task automatic model_edge(input bit vp, input bit fd, input bit sd, input bit ed);
    bit hit;
    m_exp = C_NONE;
    if (!m_started || m_finished) begin
      if (vp) begin
        int p, g;
        p = clampi(int'(i_cnfg_p), P_MAX);
        g = clampi(int'(i_cnfg_g), G_MAX);
        m_started = 1; m_finished = 0; m_gen = 0; m_q.delete();
        for (int gi = 0; gi < g; gi++) begin
          for (int k = 0; k < p; k++) m_q.push_back(k);
          if (gi < g - 1) begin m_q.push_back(C_SEL); m_q.push_back(C_EVO); end
        end
        model_next();
      end
    end else begin
      hit = (m_wait == 1 && fd) || (m_wait == 2 && sd) || (m_wait == 3 && ed);
      if (hit) begin
        if (m_wait == 3) m_gen++;
        m_wait = 0;
        if (m_q.size() == 0) begin m_finished = 1; m_idx = 0; end
        else model_next();
      end
    end
  endtask

  task automatic compare();
    if (rst) begin
      model_reset();
      chk("rst_fit_start", o_fit_start, 0); chk("rst_sel_start", o_sel_start, 0);
      chk("rst_evo_start", o_evo_start, 0); chk("rst_fit_idx", o_fit_idx, 0);
      chk("rst_gen", o_gen_cntr, 0);        chk("rst_valid", o_valid_lvl, 0);
      chk("rst_ready", ga_ready, 0);        chk("rst_err", o_err, 0);
    end else begin
      chk("fit_start", o_fit_start, m_exp >= 0);
      chk("sel_start", o_sel_start, m_exp == C_SEL);
      chk("evo_start", o_evo_start, m_exp == C_EVO);
      chk("fit_idx", o_fit_idx, m_idx);
      chk("gen_cntr", o_gen_cntr, m_gen);
      chk("valid_lvl", o_valid_lvl, m_finished);
      chk("ga_ready", ga_ready, !m_started || m_finished);
      chk("err", o_err, 0);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst) model_reset();
      else model_edge(i_valid_pls, i_fit_done, i_sel_done, i_evo_done);
      @(negedge clk);
      if (chk_en) compare();
    end
  end

  task automatic step(input bit vp, input bit fd, input bit sd, input bit ed);
    i_valid_pls = vp; i_fit_done = fd; i_sel_done = sd; i_evo_done = ed;
    @(posedge clk); #2;
  endtask

  int fit_log[$];
  int sel_n, evo_n;
  bit aborted;

  // Runs one sample acting as the three sub-units; abort_gen>=0 resets inside EVO_WAIT of that gen.
  task automatic run_sample(input int p, input int g, input bit noise, input int abort_gen);
    int kind, delay, cyc, cur;
    bit vp, fd, sd, ed;
    i_cnfg_p = PW'(p); i_cnfg_g = GW'(g);
    fit_log.delete(); sel_n = 0; evo_n = 0; aborted = 0;
    kind = 0; delay = 0; cyc = 0;
    step(1, 0, 0, 0);
    while (!o_valid_lvl && cyc < 20000) begin
      vp = 0; fd = 0; sd = 0; ed = 0; cyc++;
      if (o_fit_start) begin
        fit_log.push_back(int'(o_fit_idx)); kind = 1;
        delay = noise ? int'($urandom_range(1, 3)) : 1;
      end else if (o_sel_start) begin
        sel_n++; kind = 2; delay = noise ? int'($urandom_range(1, 3)) : 1;
      end else if (o_evo_start) begin
        evo_n++;
        if (abort_gen >= 0 && int'(o_gen_cntr) == abort_gen) begin
          i_valid_pls = 0; i_fit_done = 0; i_sel_done = 0; i_evo_done = 0;
          rst = 1; #1;
          chk("abort_fit_start", o_fit_start, 0); chk("abort_evo_start", o_evo_start, 0);
          chk("abort_gen", o_gen_cntr, 0);        chk("abort_ready", ga_ready, 0);
          chk("abort_valid", o_valid_lvl, 0);     chk("abort_idx", o_fit_idx, 0);
          #1;
          step(0, 0, 0, 0); step(0, 0, 0, 0);
          rst = 0;
          step(0, 0, 0, 1);
          step(0, 0, 0, 0); step(0, 0, 0, 0);
          chk("late_evo_ready", ga_ready, 1);
          chk("late_evo_gen", o_gen_cntr, 0);
          aborted = 1;
          return;
        end
        kind = 3; delay = noise ? int'($urandom_range(1, 3)) : 1;
      end else if (kind != 0) begin
        delay--;
        if (delay == 0) begin
          fd = (kind == 1); sd = (kind == 2); ed = (kind == 3); kind = 0;
          cur = fd ? 1 : (sd ? 2 : 3);
        end
      end
      if (fd || sd || ed) cur = fd ? 1 : (sd ? 2 : 3);
      else cur = kind;
      if (noise) begin
        vp = ($urandom_range(0, 3) == 0);
        if (cur != 1) fd = ($urandom_range(0, 2) == 0);
        if (cur != 2) sd = ($urandom_range(0, 2) == 0);
        if (cur != 3) ed = ($urandom_range(0, 2) == 0);
      end
      step(vp, fd, sd, ed);
    end
    chk("sample_completes", o_valid_lvl, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp27[6];
    int p, g;
    rst = 1; chk_en = 1;
    i_cnfg_p = '0; i_cnfg_g = '0;
    i_valid_pls = 0; i_fit_done = 0; i_sel_done = 0; i_evo_done = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_ready_low", ga_ready, 0);
    rst = 0;
    step(0, 0, 0, 0);
    chk("post_reset_ready", ga_ready, 1);
    chk("post_reset_gen", o_gen_cntr, 0);

    // P=3, G=2 with single-cycle responses
    run_sample(3, 2, 0, -1);
    exp27 = '{0, 1, 2, 0, 1, 2};
    chk("p3g2_fit_count", fit_log.size(), 6);
    for (int i = 0; i < 6 && i < fit_log.size(); i++) chk("p3g2_fit_idx", fit_log[i], exp27[i]);
    chk("p3g2_sel_count", sel_n, 1);
    chk("p3g2_evo_count", evo_n, 1);
    chk("p3g2_gen", o_gen_cntr, 1);
    chk("p3g2_valid", o_valid_lvl, 1);

    // noisy run: ignored valid pulses and stray done pulses, restarted straight from DONE
    run_sample(4, 3, 1, -1);
    chk("p4g3_fit_count", fit_log.size(), 12);
    chk("p4g3_evo_count", evo_n, 2);
    chk("p4g3_gen", o_gen_cntr, 2);

    for (int r = 0; r < 6; r++) begin
      p = int'($urandom_range(0, 6));
      g = int'($urandom_range(0, 4));
      run_sample(p, g, 1, -1);
      chk("rand_fit_count", fit_log.size(), clampi(p, P_MAX) * clampi(g, G_MAX));
      chk("rand_gen", o_gen_cntr, clampi(g, G_MAX) - 1);
    end

    run_sample(1500, 1, 1, -1);
    chk("pclamp_fit_count", fit_log.size(), 1024);
    if (fit_log.size() > 0) chk("pclamp_last_idx", fit_log[fit_log.size() - 1], 1023);

    // p=0 clamps to 1, g=2000 clamps to 1024
    run_sample(0, 2000, 0, -1);
    chk("clamp_fit_count", fit_log.size(), 1024);
    chk("clamp_evo_count", evo_n, 1023);
    chk("clamp_gen", o_gen_cntr, 1023);
    chk("clamp_idx_nonzero_seen", fit_log.sum() with (int'(item != 0)), 0);

    run_sample(2, 10, 1, 5);
    chk("abort_reached", aborted, 1);

    // stray selection done while waiting on fitness
    i_cnfg_p = PW'(1); i_cnfg_g = GW'(1);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("stray_sel_no_evo", o_evo_start, 0);
    chk("stray_sel_no_sel", o_sel_start, 0);
    chk("stray_sel_busy", ga_ready, 0);
    step(0, 1, 0, 0);
    chk("stray_sel_done_valid", o_valid_lvl, 1);

`ifdef GA_GEN_CTRL_TIMEOUT_EN
    chk_en = 0;
    i_cnfg_p = PW'(2); i_cnfg_g = GW'(1);
    step(1, 0, 0, 0);
    repeat (10) step(0, 0, 0, 0);
    chk("tmo_err_before", o_err, 0);
    chk("tmo_busy_before", ga_ready, 0);
    step(0, 0, 0, 0);
    chk("tmo_err", o_err, 1);
    chk("tmo_ready", ga_ready, 1);
    chk("tmo_valid", o_valid_lvl, 0);
    step(0, 1, 0, 0);
    chk("tmo_err_sticky", o_err, 1);
    step(1, 0, 0, 0);
    chk("tmo_err_cleared", o_err, 0);
    rst = 1;
    step(0, 0, 0, 0);
    chk_en = 1;
    rst = 0;
    step(0, 0, 0, 0);
    run_sample(2, 2, 0, -1);
    chk("tmo_after_fit_count", fit_log.size(), 4);
`endif

    step(0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
